// File: rtl/utop.sv
// utop: assembles eight indexed 200-bit beats into one lane-mapped 1600-bit Keccak state.
// Optional macro UTOP_IXCHECK_EN enforces in-order beat indices; without it dinix is only recorded.
module utop #(
    parameter int TMO = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pushin,
    input  logic [2:0]            dinix,
    input  logic [199:0]          din,
    output logic                  pushout,
    output logic [23:0]           dix,
    output logic [4:0][4:0][63:0] dout,
    output logic                  err
);
    localparam int GW = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((TMO == 0) ? 0 : TMO - 1);

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1399:0] s_q;
    logic [20:0]   dixbuf_q;
    logic [1599:0] dout_q;
    logic [23:0]   dix_q;
    logic          pushout_q, pushout_d;
    logic          err_q, err_d;
    logic          wr_en, done, mism, tmo_hit;
    logic [2:0]    wr_slot;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            gap_q     <= '0;
            pushout_q <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= '0;
            dix_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            pushout_q <= pushout_d;
            err_q     <= err_d;
            // Beat 7 bypasses the buffer and lands straight in the output register.
            if (done) begin
                dout_q <= {din, s_q};
                dix_q  <= {dinix, dixbuf_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 7; i++) begin
            if (wr_en && wr_slot == 3'(i)) begin
                s_q[200*i +: 200]    <= din;
                dixbuf_q[3*i +: 3]   <= dinix;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        wr_en   = 1'b0;
        wr_slot = cnt_q;
        mism    = 1'b0;
        tmo_hit = 1'b0;
        done    = 1'b0;
        if (pushin) begin
            gap_d = '0;
`ifdef UTOP_IXCHECK_EN
            if (dinix != cnt_q) begin
                mism = 1'b1;
                if (dinix == 3'd0) begin
                    wr_en   = 1'b1;
                    wr_slot = 3'd0;
                    cnt_d   = 3'd1;
                    state_d = COLLECT;
                end else begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end
            end else
`endif
            begin
                wr_en = 1'b1;
                if (cnt_q == 3'd7) begin
                    done    = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = COLLECT;
                end
            end
        end else if (state_q == COLLECT && TMO != 0) begin
            if (gap_q == GAP_LAST) begin
                tmo_hit = 1'b1;
                cnt_d   = 3'd0;
                gap_d   = '0;
                state_d = IDLE;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end
    end

    always_comb begin
        pushout_d = done;
        err_d     = mism | tmo_hit;
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_x
            for (gj = 0; gj < 5; gj++) begin : g_y
                assign dout[gi][gj] = dout_q[64*(5*gj+gi) +: 64];
            end
        end
    endgenerate

    assign pushout = pushout_q;
    assign err     = err_q;
    assign dix     = dix_q;
endmodule

// File: tb/tb_utop.sv
// tb_utop: table-driven vectors plus hand-written corner sequences, with a frame scoreboard.
module tb_utop;
    localparam int TMO = 4;
    localparam logic [23:0] IX_ORD = 24'hFAC688;

    typedef logic [4:0][4:0][63:0] lanes_t;
    typedef logic [199:0] beats_t [8];
    typedef struct {
        logic        rst;
        logic        p;
        logic [2:0]  ix;
        logic [199:0] d;
        logic        po;
        logic        er;
        logic        sb_push;
        lanes_t      sb_st;
        logic [23:0] sb_ix;
    } vec_t;
    typedef struct {
        lanes_t      st;
        logic [23:0] ix;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         pushin = 1'b0;
    logic [2:0]   dinix = 3'd0;
    logic [199:0] din = '0;
    logic         pushout, err;
    logic [23:0]  dix;
    lanes_t       dout;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    vec_t vt[$];
    int   po_cyc[$];

    utop #(.TMO(TMO)) dut (
        .clk(clk), .reset(reset), .pushin(pushin), .dinix(dinix), .din(din),
        .pushout(pushout), .dix(dix), .dout(dout), .err(err)
    );

    always #5 clk = ~clk;

    function automatic lanes_t to_lanes(input logic [1599:0] s);
        lanes_t r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    r[x][y][z] = s[64*(5*y+x)+z];
        return r;
    endfunction

    function automatic logic [1599:0] to_flat(input lanes_t a);
        logic [1599:0] s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    s[64*(5*y+x)+z] = a[x][y][z];
        return s;
    endfunction

    function automatic logic [1599:0] cat8(input beats_t b);
        logic [1599:0] s;
        for (int k = 0; k < 8; k++) s[200*k +: 200] = b[k];
        return s;
    endfunction

    function automatic logic [199:0] rnd200();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
        return t[199:0];
    endfunction

    function automatic lanes_t rnd_lanes();
        lanes_t r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = {$urandom, $urandom};
        return r;
    endfunction

    function automatic logic [199:0] ord_beat(input int k);
        logic [199:0] r;
        r = {200{k[0]}} ^ 200'(k);
        return r;
    endfunction

    function automatic vec_t mkv(input logic rst, input logic p, input logic [2:0] ix,
                                 input logic [199:0] d, input logic po, input logic er);
        vec_t v;
        v.rst = rst; v.p = p; v.ix = ix; v.d = d; v.po = po; v.er = er;
        v.sb_push = 1'b0; v.sb_st = '0; v.sb_ix = '0;
        return v;
    endfunction

    task automatic fill(output beats_t b);
        for (int k = 0; k < 8; k++) b[k] = rnd200();
    endtask

    task automatic add(input logic p, input logic [2:0] ix, input logic [199:0] d,
                       input logic po, input logic er);
        vt.push_back(mkv(1'b0, p, ix, d, po, er));
    endtask

    task automatic add_first(input logic [199:0] d, input lanes_t st, input logic [23:0] six);
        vec_t v;
        v = mkv(1'b0, 1'b1, 3'd0, d, 1'b0, 1'b0);
        v.sb_push = 1'b1; v.sb_st = st; v.sb_ix = six;
        vt.push_back(v);
    endtask

    task automatic add_rst();
        vt.push_back(mkv(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0));
    endtask

    task automatic push_exp(input lanes_t st, input logic [23:0] six);
        exp_t e;
        e.st = st; e.ix = six;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic chk_lanes(input string name, input lanes_t act, input lanes_t req);
        int bx, by;
        bx = -1; by = -1;
        total++;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                if (bx < 0 && act[x][y] !== req[x][y]) begin bx = x; by = y; end
        if (bx >= 0) begin
            bad++;
            $display("FAIL %s: lane[%0d][%0d] got %h want %h", name, bx, by, act[bx][by], req[bx][by]);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        exp_t e;
        reset  = ~v.rst;
        pushin = v.p;
        dinix  = v.ix;
        din    = v.d;
        if (v.sb_push) push_exp(v.sb_st, v.sb_ix);
        @(posedge clk);
        #1;
        cyc++;
        pushin = 1'b0;
        reset  = 1'b1;
        chk({tag, "/pushout"}, 64'(pushout), 64'(v.po));
        chk({tag, "/err"}, 64'(err), 64'(v.er));
        if (v.rst) begin
            chk({tag, "/dix_reset"}, 64'(dix), 64'd0);
            chk_lanes({tag, "/dout_reset"}, dout, '0);
        end
        if (pushout === 1'b1) begin
            po_cyc.push_back(cyc);
            $display("frame out at cycle %0d tag=%s dix=%h", cyc, tag, dix);
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL %s/unexpected_pushout: got pushout=1 want no pending frame", tag);
            end else begin
                e = sb.pop_front();
                chk_lanes({tag, "/dout"}, dout, e.st);
                chk({tag, "/dix"}, 64'(dix), 64'(e.ix));
            end
        end
    endtask

    initial begin
        beats_t a, b, c, r;
        lanes_t la, lb;
        logic [1599:0] fl;
        logic [199:0] cb;

        // Reset state, an idle cycle in IDLE, then an ordered frame.
        add_rst();
        add_rst();
        add(1'b0, 3'd0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) a[k] = ord_beat(k);
        add_first(a[0], to_lanes(cat8(a)), IX_ORD);
        for (int k = 1; k < 8; k++) add(1'b1, 3'(k), a[k], k == 7, 1'b0);

        // Index 0 arriving mid-frame.
        fill(a); fill(b);
`ifdef UTOP_IXCHECK_EN
        add_first(a[0], to_lanes(cat8(b)), IX_ORD);
        add(1'b1, 3'd1, a[1], 1'b0, 1'b0);
        add(1'b1, 3'd2, a[2], 1'b0, 1'b0);
        add(1'b1, 3'd0, b[0], 1'b0, 1'b1);
        for (int k = 1; k < 8; k++) add(1'b1, 3'(k), b[k], k == 7, 1'b0);
`else
        r = '{a[0], a[1], a[2], b[0], b[1], b[2], b[3], b[4]};
        add_first(a[0], to_lanes(cat8(r)),
                  {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0});
        add(1'b1, 3'd1, a[1], 1'b0, 1'b0);
        add(1'b1, 3'd2, a[2], 1'b0, 1'b0);
        add(1'b1, 3'd0, b[0], 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) add(1'b1, 3'(k), b[k], k == 4, 1'b0);
`endif
        add_rst();

        // Non-zero index out of order.
        fill(a); fill(c); cb = rnd200();
`ifdef UTOP_IXCHECK_EN
        add(1'b1, 3'd0, a[0], 1'b0, 1'b0);
        add(1'b1, 3'd1, a[1], 1'b0, 1'b0);
        add(1'b1, 3'd5, cb, 1'b0, 1'b1);
        add_first(c[0], to_lanes(cat8(c)), IX_ORD);
        for (int k = 1; k < 8; k++) add(1'b1, 3'(k), c[k], k == 7, 1'b0);
`else
        r = '{a[0], a[1], cb, c[0], c[1], c[2], c[3], c[4]};
        add_first(a[0], to_lanes(cat8(r)),
                  {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd1, 3'd0});
        add(1'b1, 3'd1, a[1], 1'b0, 1'b0);
        add(1'b1, 3'd5, cb, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) add(1'b1, 3'(k), c[k], k == 4, 1'b0);
`endif
        add_rst();

        for (int i = 0; i < vt.size(); i++) step(vt[i], $sformatf("vec%0d", i));

        // Timeout after TMO idle cycles, then TMO-1 idle cycles mid-frame are tolerated.
        fill(a);
        step(mkv(1'b0, 1'b1, 3'd0, a[0], 1'b0, 1'b0), "tmo_b0");
        step(mkv(1'b0, 1'b1, 3'd1, a[1], 1'b0, 1'b0), "tmo_b1");
        for (int i = 0; i < TMO; i++)
            step(mkv(1'b0, 1'b0, 3'd0, '0, 1'b0, i == TMO - 1), $sformatf("tmo_idle%0d", i));
        step(mkv(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0), "tmo_after");
        fill(b);
        push_exp(to_lanes(cat8(b)), IX_ORD);
        step(mkv(1'b0, 1'b1, 3'd0, b[0], 1'b0, 1'b0), "gap_b0");
        step(mkv(1'b0, 1'b1, 3'd1, b[1], 1'b0, 1'b0), "gap_b1");
        for (int i = 0; i < TMO - 1; i++)
            step(mkv(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0), $sformatf("gap_idle%0d", i));
        for (int k = 2; k < 8; k++)
            step(mkv(1'b0, 1'b1, 3'(k), b[k], k == 7, 1'b0), $sformatf("gap_b%0d", k));

        // Reset after beat 5 loses the frame and clears the outputs.
        fill(a);
        for (int k = 0; k < 6; k++)
            step(mkv(1'b0, 1'b1, 3'(k), a[k], 1'b0, 1'b0), $sformatf("rstmid_b%0d", k));
        step(mkv(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0), "rstmid_reset");
        fill(b);
        push_exp(to_lanes(cat8(b)), IX_ORD);
        for (int k = 0; k < 8; k++)
            step(mkv(1'b0, 1'b1, 3'(k), b[k], k == 7, 1'b0), $sformatf("rstmid_f%0d", k));

        // Round trip of two back-to-back serialized states.
        la = rnd_lanes(); lb = rnd_lanes();
        po_cyc.delete();
        push_exp(la, IX_ORD);
        fl = to_flat(la);
        for (int k = 0; k < 8; k++)
            step(mkv(1'b0, 1'b1, 3'(k), fl[200*k +: 200], k == 7, 1'b0), $sformatf("rt0_b%0d", k));
        push_exp(lb, IX_ORD);
        fl = to_flat(lb);
        for (int k = 0; k < 8; k++)
            step(mkv(1'b0, 1'b1, 3'(k), fl[200*k +: 200], k == 7, 1'b0), $sformatf("rt1_b%0d", k));
        if (po_cyc.size() != 2) begin
            total++; bad++;
            $display("FAIL rt/pulse_count: got %0d want 2", po_cyc.size());
        end else begin
            chk("rt/spacing", 64'(po_cyc[1] - po_cyc[0]), 64'd8);
        end

        // Output register holds while the next frame is collected.
        fill(c);
        for (int k = 0; k < 3; k++)
            step(mkv(1'b0, 1'b1, 3'(k), c[k], 1'b0, 1'b0), $sformatf("hold_b%0d", k));
        for (int i = 0; i < 2; i++)
            step(mkv(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0), $sformatf("hold_idle%0d", i));
        chk_lanes("hold/dout", dout, lb);
        chk("hold/dix", 64'(dix), 64'(IX_ORD));
        step(mkv(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0), "final_reset");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/utop.md
# utop

Unpacker-to-permutation assembler: collects eight 200-bit beats, each tagged with a 3-bit beat index, into one 1600-bit Keccak state. It then presents the state in lane form `[x][y][z]` to the SHA3-256 permutation engine, together with a 24-bit index word. It sits on the input side of the permutation datapath and is the mirror of the engine's output serializer, which emits the same 8×200-bit beat format.

## Interface
- `TMO`, default 64: idle-gap timeout, in cycles, for a partially collected frame. 0 disables the timeout.
- `clk` in 1: clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `pushin` in 1: beat valid. There is no backpressure; every asserted cycle is a beat.
- `dinix` in 3: beat index of `din`. 0 is the least-significant 200 bits of the state.
- `din` in 200: beat data.
- `pushout` out 1: one-cycle pulse when an assembled state is valid on `dout`/`dix`.
- `dix` out 24: concatenated accepted indices `{ix7,…,ix0}`; `ix0` is in bits [2:0].
- `dout` out [4:0][4:0][63:0]: assembled state, lane-mapped.
- `err` out 1: one-cycle pulse on a protocol error (index mismatch or timeout).

## Operation
- **Flat state and lane mapping.** The assembly buffer `S[1599:0]` holds the flat state; beat slot k occupies `S[200k+199:200k]`. Lane mapping: `dout[x][y][z] = S[64*(5y+x)+z]` for x,y∈0..4, z∈0..63.
- **Two-state FSM: IDLE and COLLECT.**
  - Beat counter `cnt` (3 bits) gives the expected slot of the next beat.
  - Gap counter `gap` counts cycles since the last accepted beat.
- **IDLE.** On `pushin` with an accepted beat 0, write slot 0, set `cnt`=1 and move to COLLECT.
- **COLLECT.**
  - On an accepted beat, write slot `cnt` and record the index at `dix_buf[3cnt+2:3cnt]`, then increment `cnt` and clear `gap`.
  - After beat 7 is written, copy `S` to the `dout` register and `dix_buf` to `dix`, pulse `pushout`, set `cnt`=0 and return to IDLE.
- **Beat acceptance** applies in both states and depends on `UTOP_IXCHECK_EN` (see Configuration).
  - With the check: a beat is accepted only if `dinix == cnt`.
  - On a mismatch with `dinix == 0`: pulse `err`, discard the partial frame, and accept this beat as beat 0 of a new frame (`cnt`=1, COLLECT).
  - On a mismatch with `dinix != 0`: pulse `err`, discard the beat and the partial frame, and go to IDLE with `cnt`=0.
- **Timeout.** If `TMO != 0` and the FSM is in COLLECT with no `pushin` for `TMO` consecutive cycles, pulse `err`, discard the partial frame and go to IDLE.
  - A `pushin` in the same cycle that `gap` reaches `TMO` takes priority: the beat is processed and no timeout occurs.
- **Output hold.** `dout` and `dix` are a separate output register. They hold the last completed frame until the next completion, so collecting the next frame never disturbs them.
- **Reset.** While `reset`=0 at a clock edge:
  - `pushout`=0, `err`=0, `dout`=0, `dix`=0.
  - `cnt`=0, `gap`=0, FSM=IDLE.
  - `S` and `dix_buf` need not be cleared.
- **Reset mid-frame.** The partial frame is lost and no `pushout` is generated.

## Timing
- **Latency.** `pushout`, `dout` and `dix` update in the cycle after the edge that samples beat 7.
- **Pulse width.** `pushout` and `err` are registered one-cycle pulses and never assert in the same cycle.
- **Throughput.** One frame per 8 cycles, back-to-back. Beat 0 of frame N+1 may arrive in the cycle after beat 7 of frame N.
- **Gaps.** Any number of idle cycles between beats is legal, subject to `TMO`.
- **Arithmetic.** `cnt` increments modulo 8. `gap` saturates at `TMO` and is never wider than needed for `TMO`.

## Configuration
- **`UTOP_IXCHECK_EN` defined:** index checking exactly as in Operation.
  - `dix` reflects the received indices, which equal `{3'd7,3'd6,…,3'd0}` = 24'hFAC688 on every completed frame.
- **`UTOP_IXCHECK_EN` undefined:**
  - `dinix` is ignored for placement; every beat is accepted into slot `cnt`.
  - `dix_buf` still records `dinix` as received.
  - Mismatch errors never occur; `err` pulses only on timeout.

## Test plan
- **Ordered frame.** Reset, then 8 consecutive beats with `dinix`=k and `din`={200{k[0]}} ^ k → `pushout` one cycle after beat 7; `dout` is the matching lane-mapped state; `dix`=24'hFAC688; `err`=0.
- **Round trip.** Feed the output serializer's 8-beat stream from a random state → `dout` equals the original `[x][y][z]` state; two back-to-back frames yield two `pushout` pulses exactly 8 cycles apart.
- **Restart on index 0.** Beats 0,1,2, then index 0 (check on) → `err` pulse at the 4th beat; the frame restarts; 7 further beats 1..7 produce `pushout`, and `dout` contains the restarted data.
- **Bad index.** Beats 0,1, then index 5 → `err` pulse, FSM in IDLE; beats 0..7 afterwards complete normally. With the macro undefined, the same stimulus instead completes a frame after 8 beats, with index 5 recorded in `dix`[8:6].
- **Timeout.** `TMO`=4; beats 0,1, then 4 idle cycles → `err` pulse, no `pushout`. Repeat with 3 idle cycles → no error, and the frame completes.
- **Reset mid-frame.** Assert `reset`=0 after beat 5 → `pushout`/`err`/`dout`/`dix` all 0; 8 fresh beats then complete correctly.
